icache_fill_ctrl: RTL

Fill/prefetch controller on the write side of the 2-way, 16-set instruction cache storage: detects fetch misses, issues line loads to memory, runs a sequential next-line prefetcher, tracks outstanding loads by memory tag and writes returned lines into the cache write port. Sits between fetch, the cache storage and the memory bus.

---
 rtl/icache_pkg.sv | 46 ++++
 rtl/icache_mshr.sv | 90 +++++++++
 rtl/icache_fill_ctrl.sv | 164 ++++++++++++++++
 3 files changed

// File: rtl/icache_pkg.sv
// icache_pkg: shared types and constants for the instruction-cache fill path.
//   - bus_cmd_t     : processor-to-memory command encodings
//   - line_t        : 13-bit line address (fetch PC bits [15:3])
//   - mshr_entry_t  : one outstanding-load record (valid, memory tag, line)
//   - helpers to split a line into cache index/tag and to form a bus address
package icache_pkg;

  localparam int LINE_W = 13;
  localparam int IDX_W  = 4;
  localparam int TAG_W  = 9;
  localparam int MTAG_W = 4;

  typedef enum logic [1:0] {
    BUS_NONE  = 2'd0,
    BUS_LOAD  = 2'd1,
    BUS_STORE = 2'd2
  } bus_cmd_t;

  typedef logic [LINE_W-1:0] line_t;

  typedef struct packed {
    logic              valid;
    logic [MTAG_W-1:0] mem_tag;
    line_t             line;
  } mshr_entry_t;

  localparam line_t       LINE_ZERO  = 13'd0;
  localparam line_t       LINE_ONE   = 13'd1;
  localparam mshr_entry_t MSHR_EMPTY = '{valid: 1'b0, mem_tag: 4'd0, line: 13'd0};

  // Cache set index is the low four bits of the line address.
  function automatic logic [IDX_W-1:0] line_idx(input line_t line);
    return line[IDX_W-1:0];
  endfunction

  // Cache tag is everything above the index.
  function automatic logic [TAG_W-1:0] line_tag(input line_t line);
    return line[LINE_W-1:IDX_W];
  endfunction

  // Byte address of a line on the memory bus: upper and offset bits are zero.
  function automatic logic [63:0] line_addr(input line_t line);
    return {48'd0, line, 3'd0};
  endfunction

endpackage

// File: rtl/icache_mshr.sv
// icache_mshr: outstanding-load table for the instruction-cache fill path.
// Ports:
//   clock, reset            - clock, asynchronous active-high reset
//   alloc_en/tag/line       - record an accepted load in the lowest free slot
//   ret_tag                 - memory return tag (0 = no return this cycle)
//   ret_hit/ret_line        - a valid entry owns ret_tag, and its line address
//   dmd_line/dmd_match      - demand line already outstanding
//   pf_line/pf_match        - prefetch candidate already outstanding
//   has_free/full           - free-slot status as of the start of the cycle
module icache_mshr
  import icache_pkg::*;
#(
  parameter int NUM_MSHR = 4
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              alloc_en,
  input  logic [MTAG_W-1:0] alloc_tag,
  input  line_t             alloc_line,
  input  logic [MTAG_W-1:0] ret_tag,
  output logic              ret_hit,
  output line_t             ret_line,
  input  line_t             dmd_line,
  output logic              dmd_match,
  input  line_t             pf_line,
  output logic              pf_match,
  output logic              has_free,
  output logic              full
);

  mshr_entry_t         entry_r [NUM_MSHR];
  logic [NUM_MSHR-1:0] alloc_oh_s;
  logic [NUM_MSHR-1:0] ret_oh_s;

  // Table lookups: lowest free slot, lowest slot owning the return tag, line matches.
  // Free status is taken from registered state only, so a slot retiring this
  // cycle is not offered for allocation until the next one.
  always_comb begin
    logic alloc_taken;
    logic ret_taken;
    alloc_taken = 1'b0;
    ret_taken   = 1'b0;
    alloc_oh_s  = {NUM_MSHR{1'b0}};
    ret_oh_s    = {NUM_MSHR{1'b0}};
    ret_line    = LINE_ZERO;
    dmd_match   = 1'b0;
    pf_match    = 1'b0;
    for (int i = 0; i < NUM_MSHR; i++) begin
      if (!entry_r[i].valid && !alloc_taken) begin
        alloc_oh_s[i] = 1'b1;
        alloc_taken   = 1'b1;
      end else begin
        alloc_oh_s[i] = 1'b0;
      end
      if (entry_r[i].valid && (ret_tag != {MTAG_W{1'b0}}) &&
          (entry_r[i].mem_tag == ret_tag) && !ret_taken) begin
        ret_oh_s[i] = 1'b1;
        ret_taken   = 1'b1;
        ret_line    = entry_r[i].line;
      end else begin
        ret_oh_s[i] = 1'b0;
      end
      dmd_match = dmd_match | (entry_r[i].valid && (entry_r[i].line == dmd_line));
      pf_match  = pf_match  | (entry_r[i].valid && (entry_r[i].line == pf_line));
    end
    ret_hit  = ret_taken;
    has_free = alloc_taken;
    full     = !alloc_taken;
  end

  // Entry storage: fill the chosen free slot, invalidate the slot whose line returned.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < NUM_MSHR; i++) begin
        entry_r[i] <= MSHR_EMPTY;
      end
    end else begin
      for (int i = 0; i < NUM_MSHR; i++) begin
        if (alloc_en && alloc_oh_s[i]) begin
          entry_r[i] <= '{valid: 1'b1, mem_tag: alloc_tag, line: alloc_line};
        end else if (ret_oh_s[i]) begin
          entry_r[i].valid <= 1'b0;
        end else begin
          entry_r[i] <= entry_r[i];
        end
      end
    end
  end

endmodule

// File: rtl/icache_fill_ctrl.sv
// icache_fill_ctrl: miss detection, next-line prefetch and line fill for the
// 2-way, 16-set instruction cache.
// Ports:
//   clock, reset                     - clock, asynchronous active-high reset
//   fetch_addr, fetch_en             - fetch PC and request strobe
//   rd_idx, rd_tag, cache_rd_valid   - demand lookup and its hit result
//   pf_idx, pf_tag, cache_pf_valid   - prefetch-candidate lookup and its hit result
//   wr_en, wr_idx, wr_tag, wr_data   - cache fill write port
//   proc2mem_command, proc2mem_addr  - line load request to memory
//   mem2proc_response                - nonzero: request accepted with this tag
//   mem2proc_data, mem2proc_tag      - returned line and its tag (0 = none)
//   fetch_stall                      - demand line not yet present
module icache_fill_ctrl
  import icache_pkg::*;
#(
  parameter int NUM_MSHR = 4,
  parameter int PF_DEPTH = 4
) (
  input  logic              clock,
  input  logic              reset,
  input  logic [63:0]       fetch_addr,
  input  logic              fetch_en,
  input  logic              cache_rd_valid,
  input  logic              cache_pf_valid,
  output logic [IDX_W-1:0]  rd_idx,
  output logic [TAG_W-1:0]  rd_tag,
  output logic [IDX_W-1:0]  pf_idx,
  output logic [TAG_W-1:0]  pf_tag,
  output logic              wr_en,
  output logic [IDX_W-1:0]  wr_idx,
  output logic [TAG_W-1:0]  wr_tag,
  output logic [63:0]       wr_data,
  output logic [1:0]        proc2mem_command,
  output logic [63:0]       proc2mem_addr,
  input  logic [MTAG_W-1:0] mem2proc_response,
  input  logic [63:0]       mem2proc_data,
  input  logic [MTAG_W-1:0] mem2proc_tag,
  output logic              fetch_stall
);

  localparam int CNT_W = (PF_DEPTH > 0) ? $clog2(PF_DEPTH + 1) : 1;
  localparam logic [CNT_W-1:0] CNT_ZERO = CNT_W'(0);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(PF_DEPTH);

  line_t            fetch_line_s;
  line_t            pf_ptr_r;
  line_t            pf_ptr_nxt_s;
  logic [CNT_W-1:0] pf_count_r;
  logic [CNT_W-1:0] pf_count_nxt_s;

  logic     demand_miss_s;
  logic     demand_issue_s;
  logic     pf_pending_s;
  logic     pf_skip_s;
  logic     pf_issue_s;
  logic     accepted_s;
  line_t    alloc_line_s;
  bus_cmd_t cmd_s;

  logic     ret_hit_s;
  line_t    ret_line_s;
  logic     dmd_match_s;
  logic     pf_match_s;
  logic     has_free_s;
  logic     full_s;
  logic     unused_s;

  assign fetch_line_s = fetch_addr[15:3];
  assign rd_idx       = line_idx(fetch_line_s);
  assign rd_tag       = line_tag(fetch_line_s);
  assign pf_idx       = line_idx(pf_ptr_r);
  assign pf_tag       = line_tag(pf_ptr_r);
  assign fetch_stall  = fetch_en && !cache_rd_valid;
  assign unused_s     = ^{fetch_addr[63:16], fetch_addr[2:0], full_s};

  icache_mshr #(
    .NUM_MSHR (NUM_MSHR)
  ) u_mshr (
    .clock      (clock),
    .reset      (reset),
    .alloc_en   (accepted_s),
    .alloc_tag  (mem2proc_response),
    .alloc_line (alloc_line_s),
    .ret_tag    (mem2proc_tag),
    .ret_hit    (ret_hit_s),
    .ret_line   (ret_line_s),
    .dmd_line   (fetch_line_s),
    .dmd_match  (dmd_match_s),
    .pf_line    (pf_ptr_r),
    .pf_match   (pf_match_s),
    .has_free   (has_free_s),
    .full       (full_s)
  );

  // Issue arbitration (demand before prefetch), bus drive and prefetch pointer update.
  // A demand miss always re-seeds the prefetcher, whether or not it goes to the bus.
  always_comb begin
    cmd_s          = BUS_NONE;
    proc2mem_addr  = 64'd0;
    alloc_line_s   = fetch_line_s;
    pf_ptr_nxt_s   = pf_ptr_r;
    pf_count_nxt_s = pf_count_r;

    demand_miss_s  = fetch_en && !cache_rd_valid;
    demand_issue_s = demand_miss_s && !dmd_match_s && has_free_s;
    pf_pending_s   = (pf_count_r != CNT_ZERO) && !demand_issue_s;
    pf_skip_s      = pf_pending_s && (cache_pf_valid || pf_match_s);
    pf_issue_s     = pf_pending_s && !pf_skip_s && has_free_s;
    accepted_s     = (mem2proc_response != 4'd0) && (demand_issue_s || pf_issue_s);

    if (demand_issue_s) begin
      cmd_s         = BUS_LOAD;
      proc2mem_addr = line_addr(fetch_line_s);
      alloc_line_s  = fetch_line_s;
    end else if (pf_issue_s) begin
      cmd_s         = BUS_LOAD;
      proc2mem_addr = line_addr(pf_ptr_r);
      alloc_line_s  = pf_ptr_r;
    end else begin
      cmd_s         = BUS_NONE;
      proc2mem_addr = 64'd0;
    end

    if (demand_miss_s) begin
      pf_ptr_nxt_s   = fetch_line_s + LINE_ONE;
      pf_count_nxt_s = CNT_LOAD;
    end else if (pf_skip_s || (pf_issue_s && accepted_s)) begin
      pf_ptr_nxt_s   = pf_ptr_r + LINE_ONE;
      pf_count_nxt_s = pf_count_r - CNT_ONE;
    end else begin
      pf_ptr_nxt_s   = pf_ptr_r;
      pf_count_nxt_s = pf_count_r;
    end
  end

  assign proc2mem_command = cmd_s;

  // Fill port: a matched return is written through in the cycle it arrives.
  always_comb begin
    wr_data = mem2proc_data;
    if (ret_hit_s) begin
      wr_en  = 1'b1;
      wr_idx = line_idx(ret_line_s);
      wr_tag = line_tag(ret_line_s);
    end else begin
      wr_en  = 1'b0;
      wr_idx = 4'd0;
      wr_tag = 9'd0;
    end
  end

  // Prefetch pointer and remaining-lines counter.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      pf_ptr_r   <= LINE_ZERO;
      pf_count_r <= CNT_ZERO;
    end else begin
      pf_ptr_r   <= pf_ptr_nxt_s;
      pf_count_r <= pf_count_nxt_s;
    end
  end

endmodule
